dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  Consumer end of the decode stage 2 output bus: captures one muxed decoded instruction per cycle and buffers it in an in-order FIFO.
//  Steers the head entry to exactly one functional unit (FXU/LSU/BRU) by functional unit code, using a valid/ready handshake.
//  Backpressures decode through stall_o. Sits between decode stage 2 and the execution units.
// PARAMETERS
//  opcodeWidth      6   primary opcode width
//  regWidth         5   register specifier width
//  addressSize      64  instruction address width
//  XxoOpcodeWidth   10  extended opcode width
//  formatWidth      5   instruction format code width (INVALID=0 .. Z23=25)
//  QueueDepth       4   FIFO entries; power of 2, >=2
// PORTS
//  clock_i                      in   1     rising-edge clock
//  reset_i                      in   1     synchronous, active-high reset
//  enable_i                     in   1     decoded instruction valid this cycle
//  instructionAddress_i         in   addressSize  instruction address
//  opcode_i                     in   opcodeWidth  primary opcode
//  xOpcode_i, xOpcodeEnable_i   in   XxoOpcodeWidth, 1  extended opcode and its valid
//  instructionFormat_i          in   formatWidth  format code
//  imm_i, immEnable_i           in   64, 1    immediate and its valid
//  reg1_i, reg2_i, reg3_i       in   regWidth each  register specifiers
//  reg1Enable_i..reg3Enable_i   in   1 each   register valids
//  reg3IsImmediate_i, reg2ValOrZero_i  in  1 each  operand modifiers
//  bit1_i, bit2_i, bit1Enable_i, bit2Enable_i  in  1 each  flag bits and their valids
//  functionalUnitCode_i         in   2     0=FXU 1=LSU 2=BRU 3=illegal
//  stall_o                      out  1     queue full; decode must hold its outputs
//  unitValid_o                  out  3     one-hot dispatch valid [FXU,LSU,BRU]
//  unitReady_i                  in   3     per-unit accept
//  *_o payload                  out  same widths as *_i  head-entry fields, excluding enable/FU code
//  count_o                      out  clog2(QueueDepth)+1  occupancy
//  overflow_o                   out  1     sticky: enable_i seen while stall_o=1
//  illegal_o                    out  1     one-cycle pulse: FU code 3 dropped
// BEHAVIOUR
//  - Reset: head/tail pointers=0, count_o=0, stall_o=0, unitValid_o=0, overflow_o=0, illegal_o=0; payload outputs=0.
//  - Push: when enable_i && !stall_o, write the full bundle at tail and increment tail (mod QueueDepth).
//  - stall_o = (count==QueueDepth). It depends on registered state only.
//  - A push is refused when full, even if a pop occurs in the same cycle. A refused enable_i sets overflow_o until reset.
//  - Latency: an instruction pushed in cycle N is visible at the head no earlier than cycle N+1 (no bypass).
//  - Head is combinational from the storage array. unitValid_o[code] = !empty && code!=3; other bits are 0.
//  - Pop: when unitValid_o[k] && unitReady_i[k], advance head. A held head keeps all payload outputs stable (no retraction).
//  - Illegal code 3 at head: pop unconditionally in that cycle, pulse illegal_o for 1 cycle, and never assert unitValid_o.
//  - Simultaneous push and pop when not full: count unchanged; both pointers advance.
//  - Wrap-around: pointers are log2(QueueDepth) bits and wrap naturally. count is a separate counter, which distinguishes full from empty.
//  - Strictly in order: a stalled head (its unit not ready) blocks younger entries bound for other units.
//  - reset_i mid-operation: all entries are discarded the next cycle; unitValid_o drops to 0 in that cycle.
// STRUCTURE
//  - Shared package (power_isa_pkg): FU codes (FU_FXU=0, FU_LSU=1, FU_BRU=2, FU_ILLEGAL=3) and format codes (A=1..Z23=25, INVALID=0).
//    It also holds the packed decoded-instruction payload width and field offsets.
//  - Sub-module sync_fifo: parameterised width/depth storage with pointers and count.
//  - dispatch_queue adds the push guard, the steering decode and the status flags.
// TESTING
//  - Reset then idle: count_o=0, stall_o=0, unitValid_o=3'b000 on all cycles.
//  - Push FXU addr 0x100 with unitReady_i=3'b111: next cycle unitValid_o=3'b100 and instructionAddress_o=0x100; the cycle after, count_o=0.
//  - Push 4 entries with unitReady_i=0: stall_o=1 after the 4th. A 5th enable_i sets overflow_o and count_o stays 4.
//  - Head LSU, then BRU, with only unitReady_i[2]=1: unitValid_o=3'b010 held and payload stable; raising LSU ready pops it, then BRU dispatches.
//  - Push FU code 3 then FXU: illegal_o pulses once, the FXU entry follows, and no unitValid_o is seen for the illegal entry.
//  - Fill to 3, then push+pop each cycle for 10 cycles with pointer wrap: count_o stays 3 and the dispatch order matches the push order.

Source files
------------

// File: rtl/power_isa_pkg.sv
// Shared decode-bus definitions: functional unit and format codes, default field
// widths, and the layout of the packed decoded-instruction payload (LSB first).
package power_isa_pkg;

   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int ADDR_W   = 64;
   localparam int XO_W     = 10;
   localparam int FMT_W    = 5;
   localparam int IMM_W    = 64;
   localparam int FU_W     = 2;
   localparam int DEPTH    = 4;

   typedef enum logic [1:0] {
      FU_FXU     = 2'd0,
      FU_LSU     = 2'd1,
      FU_BRU     = 2'd2,
      FU_ILLEGAL = 2'd3
   } fu_code_e;

   typedef enum logic [4:0] {
      FMT_INVALID = 5'd0,  FMT_A   = 5'd1,  FMT_B   = 5'd2,  FMT_D   = 5'd3,
      FMT_DQ      = 5'd4,  FMT_DS  = 5'd5,  FMT_I   = 5'd6,  FMT_M   = 5'd7,
      FMT_MD      = 5'd8,  FMT_MDS = 5'd9,  FMT_SC  = 5'd10, FMT_VA  = 5'd11,
      FMT_VC      = 5'd12, FMT_VX  = 5'd13, FMT_X   = 5'd14, FMT_XFL = 5'd15,
      FMT_XFX     = 5'd16, FMT_XL  = 5'd17, FMT_XO  = 5'd18, FMT_XS  = 5'd19,
      FMT_XX1     = 5'd20, FMT_XX2 = 5'd21, FMT_XX3 = 5'd22, FMT_XX4 = 5'd23,
      FMT_Z22     = 5'd24, FMT_Z23 = 5'd25
   } format_e;

   // Payload = addr, opcode, xo, xoEn, fmt, imm, immEn, reg1..3, regEn[3],
   // reg3IsImm, reg2ValOrZero, bit1, bit2, bit1En, bit2En, fu (MSB to LSB).
   function automatic int payload_width(input int aw, input int ow, input int xw,
                                        input int fw, input int rw);
      return aw + ow + xw + 1 + fw + IMM_W + 1 + 3 * rw + 3 + 2 + 4 + FU_W;
   endfunction

   localparam int PAYLOAD_W = payload_width(ADDR_W, OPCODE_W, XO_W, FMT_W, REG_W);

   localparam int OFF_FU    = 0;
   localparam int OFF_BITS  = OFF_FU + FU_W;
   localparam int OFF_MOD   = OFF_BITS + 4;
   localparam int OFF_REGEN = OFF_MOD + 2;
   localparam int OFF_REG   = OFF_REGEN + 3;
   localparam int OFF_IMMEN = OFF_REG + 3 * REG_W;
   localparam int OFF_IMM   = OFF_IMMEN + 1;
   localparam int OFF_FMT   = OFF_IMM + IMM_W;
   localparam int OFF_XOEN  = OFF_FMT + FMT_W;
   localparam int OFF_XO    = OFF_XOEN + 1;
   localparam int OFF_OPC   = OFF_XO + XO_W;
   localparam int OFF_ADDR  = OFF_OPC + OPCODE_W;

endpackage

// File: rtl/sync_fifo.sv
// In-order storage FIFO. A separate occupancy counter distinguishes full from
// empty, so the pointers are plain log2(Depth)-bit values that wrap naturally.
module sync_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         wdata_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == {CntW{1'b0}});
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; push is refused when full even if popping.
   always_comb begin
      do_push_s = push_i && !full_o;
      do_pop_s  = pop_i && !empty_o;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + {{(CntW-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CntW-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   // Pointer and counter registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= {PtrW{1'b0}};
         rd_ptr_q <= {PtrW{1'b0}};
         count_q  <= {CntW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while not counted as occupied.
   always_ff @(posedge clock_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// Buffers decoded instructions from decode stage 2 and dispatches the head entry,
// in order, to FXU, LSU or BRU with a valid/ready handshake per unit.
module dispatch_queue
   import power_isa_pkg::*;
#(
   parameter int opcodeWidth    = OPCODE_W,
   parameter int regWidth       = REG_W,
   parameter int addressSize    = ADDR_W,
   parameter int XxoOpcodeWidth = XO_W,
   parameter int formatWidth    = FMT_W,
   parameter int QueueDepth     = DEPTH
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic [addressSize-1:0]        instructionAddress_i,
   input  logic [opcodeWidth-1:0]        opcode_i,
   input  logic [XxoOpcodeWidth-1:0]     xOpcode_i,
   input  logic                          xOpcodeEnable_i,
   input  logic [formatWidth-1:0]        instructionFormat_i,
   input  logic [63:0]                   imm_i,
   input  logic                          immEnable_i,
   input  logic [regWidth-1:0]           reg1_i,
   input  logic [regWidth-1:0]           reg2_i,
   input  logic [regWidth-1:0]           reg3_i,
   input  logic                          reg1Enable_i,
   input  logic                          reg2Enable_i,
   input  logic                          reg3Enable_i,
   input  logic                          reg3IsImmediate_i,
   input  logic                          reg2ValOrZero_i,
   input  logic                          bit1_i,
   input  logic                          bit2_i,
   input  logic                          bit1Enable_i,
   input  logic                          bit2Enable_i,
   input  logic [1:0]                    functionalUnitCode_i,
   output logic                          stall_o,
   output logic [2:0]                    unitValid_o,
   input  logic [2:0]                    unitReady_i,
   output logic [addressSize-1:0]        instructionAddress_o,
   output logic [opcodeWidth-1:0]        opcode_o,
   output logic [XxoOpcodeWidth-1:0]     xOpcode_o,
   output logic                          xOpcodeEnable_o,
   output logic [formatWidth-1:0]        instructionFormat_o,
   output logic [63:0]                   imm_o,
   output logic                          immEnable_o,
   output logic [regWidth-1:0]           reg1_o,
   output logic [regWidth-1:0]           reg2_o,
   output logic [regWidth-1:0]           reg3_o,
   output logic                          reg1Enable_o,
   output logic                          reg2Enable_o,
   output logic                          reg3Enable_o,
   output logic                          reg3IsImmediate_o,
   output logic                          reg2ValOrZero_o,
   output logic                          bit1_o,
   output logic                          bit2_o,
   output logic                          bit1Enable_o,
   output logic                          bit2Enable_o,
   output logic [$clog2(QueueDepth):0]   count_o,
   output logic                          overflow_o,
   output logic                          illegal_o
);

   localparam int PayloadW = payload_width(addressSize, opcodeWidth, XxoOpcodeWidth,
                                           formatWidth, regWidth);

   logic [PayloadW-1:0] wdata_s;
   logic [PayloadW-1:0] rdata_s;
   logic [PayloadW-1:0] head_s;
   logic                push_s;
   logic                pop_s;
   logic                full_s;
   logic                empty_s;
   logic                head_valid_s;
   logic [1:0]          head_fu_s;
   logic [2:0]          unit_valid_s;
   logic                illegal_s;
   logic                overflow_q, overflow_d;

   assign wdata_s = {instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
                     instructionFormat_i, imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
                     reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i,
                     reg2ValOrZero_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
                     functionalUnitCode_i};

   assign push_s = enable_i && !full_s;

   sync_fifo #(
      .Width (PayloadW),
      .Depth (QueueDepth)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (wdata_s),
      .rdata_o (rdata_s),
      .count_o (count_o),
      .empty_o (empty_s),
      .full_o  (full_s)
   );

   // A reset cycle hides the head immediately so nothing is handed out while flushing.
   assign head_valid_s = !empty_s && !reset_i;
   assign head_s       = head_valid_s ? rdata_s : {PayloadW{1'b0}};

   assign {instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
           instructionFormat_o, imm_o, immEnable_o, reg1_o, reg2_o, reg3_o,
           reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o,
           reg2ValOrZero_o, bit1_o, bit2_o, bit1Enable_o, bit2Enable_o,
           head_fu_s} = head_s;

   // Steering decode: unitValid_o is [FXU,LSU,BRU]; an illegal head is dropped at once.
   always_comb begin
      unit_valid_s = 3'b000;
      illegal_s    = 1'b0;
      if (head_valid_s) begin
         case (fu_code_e'(head_fu_s))
            FU_FXU:     unit_valid_s = 3'b100;
            FU_LSU:     unit_valid_s = 3'b010;
            FU_BRU:     unit_valid_s = 3'b001;
            FU_ILLEGAL: illegal_s    = 1'b1;
            default:    unit_valid_s = 3'b000;
         endcase
      end else begin
         unit_valid_s = 3'b000;
      end
      pop_s = illegal_s || (|(unit_valid_s & unitReady_i));
   end

   // Sticky overflow: decode presented an instruction while being told to hold.
   always_comb begin
      if (enable_i && full_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Status flag register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign stall_o     = full_s;
   assign unitValid_o = unit_valid_s;
   assign illegal_o   = illegal_s;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_dispatch_queue;

   logic        clk = 1'b0;
   logic        reset_i, enable_i;
   logic [63:0] instructionAddress_i, imm_i;
   logic [5:0]  opcode_i;
   logic [9:0]  xOpcode_i;
   logic        xOpcodeEnable_i, immEnable_i;
   logic [4:0]  instructionFormat_i, reg1_i, reg2_i, reg3_i;
   logic        reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i, reg2ValOrZero_i;
   logic        bit1_i, bit2_i, bit1Enable_i, bit2Enable_i;
   logic [1:0]  functionalUnitCode_i;
   logic [2:0]  unitReady_i;
   logic        stall_o, overflow_o, illegal_o;
   logic [2:0]  unitValid_o, count_o;
   logic [63:0] instructionAddress_o, imm_o;
   logic [5:0]  opcode_o;
   logic [9:0]  xOpcode_o;
   logic        xOpcodeEnable_o, immEnable_o;
   logic [4:0]  instructionFormat_o, reg1_o, reg2_o, reg3_o;
   logic        reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, reg2ValOrZero_o;
   logic        bit1_o, bit2_o, bit1Enable_o, bit2Enable_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dispatch_queue dut (
      .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i),
      .instructionAddress_i(instructionAddress_i), .opcode_i(opcode_i),
      .xOpcode_i(xOpcode_i), .xOpcodeEnable_i(xOpcodeEnable_i),
      .instructionFormat_i(instructionFormat_i), .imm_i(imm_i), .immEnable_i(immEnable_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .reg3_i(reg3_i),
      .reg1Enable_i(reg1Enable_i), .reg2Enable_i(reg2Enable_i), .reg3Enable_i(reg3Enable_i),
      .reg3IsImmediate_i(reg3IsImmediate_i), .reg2ValOrZero_i(reg2ValOrZero_i),
      .bit1_i(bit1_i), .bit2_i(bit2_i), .bit1Enable_i(bit1Enable_i), .bit2Enable_i(bit2Enable_i),
      .functionalUnitCode_i(functionalUnitCode_i),
      .stall_o(stall_o), .unitValid_o(unitValid_o), .unitReady_i(unitReady_i),
      .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o),
      .xOpcode_o(xOpcode_o), .xOpcodeEnable_o(xOpcodeEnable_o),
      .instructionFormat_o(instructionFormat_o), .imm_o(imm_o), .immEnable_o(immEnable_o),
      .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
      .reg1Enable_o(reg1Enable_o), .reg2Enable_o(reg2Enable_o), .reg3Enable_o(reg3Enable_o),
      .reg3IsImmediate_o(reg3IsImmediate_o), .reg2ValOrZero_o(reg2ValOrZero_o),
      .bit1_o(bit1_o), .bit2_o(bit2_o), .bit1Enable_o(bit1Enable_o), .bit2Enable_o(bit2Enable_o),
      .count_o(count_o), .overflow_o(overflow_o), .illegal_o(illegal_o)
   );

   typedef struct {
      logic        en;
      logic [63:0] addr;
      logic [1:0]  fu;
      logic [2:0]  rdy;
      logic [2:0]  uv;
      logic [2:0]  cnt;
      logic        st;
      logic        il;
      logic        ov;
      logic [63:0] haddr;
   } vec_t;

   typedef struct {
      logic [63:0] a;
      logic [1:0]  fu;
   } ent_t;

   vec_t vq[$];
   ent_t mq[$];
   logic m_ov = 1'b0;

   function automatic vec_t mk(input logic en, input logic [63:0] addr, input logic [1:0] fu,
                               input logic [2:0] rdy, input logic [2:0] uv, input logic [2:0] cnt,
                               input logic st, input logic il, input logic ov,
                               input logic [63:0] haddr);
      vec_t v;
      v.en = en; v.addr = addr; v.fu = fu; v.rdy = rdy; v.uv = uv; v.cnt = cnt;
      v.st = st; v.il = il; v.ov = ov; v.haddr = haddr;
      return v;
   endfunction

   // FU code to dispatch bit position: [FXU,LSU,BRU]
   function automatic logic [2:0] fu_onehot(input logic [1:0] fu);
      case (fu)
         2'd0:    return 3'b100;
         2'd1:    return 3'b010;
         2'd2:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // All payload fields are derived from the address so the head can be verified whole.
   task automatic drive(input logic rst, input logic en, input logic [63:0] a,
                        input logic [1:0] fu, input logic [2:0] rdy);
      reset_i = rst; enable_i = en; instructionAddress_i = a;
      opcode_i = a[5:0] ^ 6'h15; xOpcode_i = a[13:4]; xOpcodeEnable_i = a[0];
      instructionFormat_i = a[8:4]; imm_i = ~a; immEnable_i = a[1];
      reg1_i = a[4:0]; reg2_i = a[9:5]; reg3_i = a[14:10];
      reg1Enable_i = a[2]; reg2Enable_i = a[3]; reg3Enable_i = a[4];
      reg3IsImmediate_i = a[5]; reg2ValOrZero_i = a[6];
      bit1_i = a[7]; bit2_i = a[8]; bit1Enable_i = a[9]; bit2Enable_i = a[10];
      functionalUnitCode_i = fu; unitReady_i = rdy;
   endtask

   task automatic chk_payload(input string tag, input logic have, input logic [63:0] a);
      logic [63:0] ea;
      ea = have ? a : 64'd0;
      chk({tag, ".addr"}, instructionAddress_o, ea);
      chk({tag, ".imm"}, imm_o, have ? ~a : 64'd0);
      chk({tag, ".fields"},
          64'({opcode_o, xOpcode_o, reg3_o, reg2ValOrZero_o, bit2Enable_o, immEnable_o}),
          have ? 64'({ea[5:0] ^ 6'h15, ea[13:4], ea[14:10], ea[6], ea[10], ea[1]}) : 64'd0);
   endtask

   // One clock of traffic checked against the queue model, then the model advances.
   task automatic mcycle(input logic rst, input logic en, input logic [63:0] a,
                         input logic [1:0] fu, input logic [2:0] rdy);
      logic       have, full, popd;
      logic [2:0] euv;
      ent_t       h;
      drive(rst, en, a, fu, rdy);
      #1;
      have = (mq.size() > 0);
      h.a = 64'd0; h.fu = 2'd0;
      if (have) h = mq[0];
      euv = (have && !rst) ? fu_onehot(h.fu) : 3'b000;
      chk("m.unitValid", 64'(unitValid_o), 64'(euv));
      chk("m.illegal", 64'(illegal_o), 64'(have && !rst && h.fu == 2'd3));
      chk("m.overflow", 64'(overflow_o), 64'(m_ov));
      if (!rst) begin
         chk("m.count", 64'(count_o), 64'(mq.size()));
         chk("m.stall", 64'(stall_o), 64'(mq.size() == 4));
         chk_payload("m", have, h.a);
      end
      if (rst) begin
         mq.delete();
         m_ov = 1'b0;
      end else begin
         full = (mq.size() == 4);
         popd = have && (h.fu == 2'd3 || (fu_onehot(h.fu) & rdy) != 3'b000);
         if (en && full) m_ov = 1'b1;
         if (popd) void'(mq.pop_front());
         if (en && !full) mq.push_back('{a: a, fu: fu});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] a;
      logic [1:0]  fu;
      int          r;

      drive(1'b1, 1'b0, 64'd0, 2'd0, 3'b000);
      @(posedge clk); #1;
      chk("rst.count", 64'(count_o), 64'd0);
      chk("rst.stall", 64'(stall_o), 64'd0);
      chk("rst.uv", 64'(unitValid_o), 64'd0);
      @(posedge clk); #1;

      // idle, single FXU push, fill/overflow, in-order blocking, illegal drop
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0));
      vq.push_back(mk(1'b1, 64'h100, 2'd0, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b100, 3'd1, 1'b0, 1'b0, 1'b0, 64'h100));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0));
      vq.push_back(mk(1'b1, 64'h200, 2'd1, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0));
      vq.push_back(mk(1'b1, 64'h201, 2'd2, 3'b000, 3'b010, 3'd1, 1'b0, 1'b0, 1'b0, 64'h200));
      vq.push_back(mk(1'b1, 64'h202, 2'd0, 3'b000, 3'b010, 3'd2, 1'b0, 1'b0, 1'b0, 64'h200));
      vq.push_back(mk(1'b1, 64'h203, 2'd1, 3'b000, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0, 64'h200));
      vq.push_back(mk(1'b1, 64'h204, 2'd0, 3'b000, 3'b010, 3'd4, 1'b1, 1'b0, 1'b0, 64'h200));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b000, 3'b010, 3'd4, 1'b1, 1'b0, 1'b1, 64'h200));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b100, 3'b010, 3'd4, 1'b1, 1'b0, 1'b1, 64'h200));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b100, 3'b010, 3'd4, 1'b1, 1'b0, 1'b1, 64'h200));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b010, 3'b010, 3'd4, 1'b1, 1'b0, 1'b1, 64'h200));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b001, 3'b001, 3'd3, 1'b0, 1'b0, 1'b1, 64'h201));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b000, 3'b100, 3'd2, 1'b0, 1'b0, 1'b1, 64'h202));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b100, 3'd2, 1'b0, 1'b0, 1'b1, 64'h202));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b010, 3'd1, 1'b0, 1'b0, 1'b1, 64'h203));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 64'h0));
      vq.push_back(mk(1'b1, 64'h300, 2'd3, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 64'h0));
      vq.push_back(mk(1'b1, 64'h301, 2'd0, 3'b111, 3'b000, 3'd1, 1'b0, 1'b1, 1'b1, 64'h300));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b100, 3'd1, 1'b0, 1'b0, 1'b1, 64'h301));
      vq.push_back(mk(1'b0, 64'h0,   2'd0, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 64'h0));

      foreach (vq[i]) begin
         drive(1'b0, vq[i].en, vq[i].addr, vq[i].fu, vq[i].rdy);
         #1;
         chk($sformatf("v%0d.uv", i), 64'(unitValid_o), 64'(vq[i].uv));
         chk($sformatf("v%0d.count", i), 64'(count_o), 64'(vq[i].cnt));
         chk($sformatf("v%0d.stall", i), 64'(stall_o), 64'(vq[i].st));
         chk($sformatf("v%0d.illegal", i), 64'(illegal_o), 64'(vq[i].il));
         chk($sformatf("v%0d.overflow", i), 64'(overflow_o), 64'(vq[i].ov));
         chk_payload($sformatf("v%0d", i), (vq[i].uv != 3'b000) || vq[i].il, vq[i].haddr);
         @(posedge clk); #1;
      end

      // reset clears the sticky overflow and the queue
      drive(1'b1, 1'b0, 64'd0, 2'd0, 3'b000);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 64'd0, 2'd0, 3'b000);
      #1;
      chk("rst2.overflow", 64'(overflow_o), 64'd0);
      chk("rst2.count", 64'(count_o), 64'd0);
      @(posedge clk); #1;

      // fill to 3 then push+pop every cycle across pointer wrap
      for (int i = 0; i < 3; i++) mcycle(1'b0, 1'b1, 64'h400 + 64'(i), 2'd0, 3'b000);
      for (int i = 0; i < 10; i++) begin
         mcycle(1'b0, 1'b1, 64'h410 + 64'(i), 2'd0, 3'b100);
         chk("wrap.count", 64'(count_o), 64'd3);
      end
      for (int i = 0; i < 4; i++) mcycle(1'b0, 1'b0, 64'd0, 2'd0, 3'b111);

      // reset in the middle of traffic
      mcycle(1'b0, 1'b1, 64'h500, 2'd1, 3'b000);
      mcycle(1'b0, 1'b1, 64'h501, 2'd2, 3'b000);
      mcycle(1'b1, 1'b0, 64'd0, 2'd0, 3'b111);
      mcycle(1'b0, 1'b0, 64'd0, 2'd0, 3'b111);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         a  = {$urandom(), $urandom()};
         r  = $urandom_range(0, 9);
         fu = (r == 0) ? 2'd3 : 2'(r % 3);
         mcycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), a, fu,
                3'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
